// File: rtl/register_status_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_status_file_pkg / register_status_file                         |
// | Architectural register file with rename status, fed by the reorder      |
// | buffer (commit, speculate, flush, live ROB contents) and the CDB.       |
// | For each source operand it returns either a ready value or the ROB tag  |
// | that will produce it.                                                    |
// | Ports: clk, rst (sync, active-high); fls_i; commit_i/_idx_i/_val_i/     |
// |   _rob_idx_i; speculate_i/_idx_i/_val_i; rob_bus_i; common_data_bus_i;  |
// |   rs_idx_i -> rs_rdy_o, rs_val_o, rs_tag_o per read port; busy_count_o. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package register_status_file_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_IDX_LEN = 4;
    localparam int ROB_ENTRIES = 1 << ROB_IDX_LEN;
    localparam int CDB_LANES   = 2;

    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            rdy;
    } rob_element_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_IDX_LEN-1:0] rob_dest;
        logic [XLEN-1:0]        data;
    } cdb_lane_t;

    typedef cdb_lane_t [CDB_LANES-1:0] common_data_bus_t;
endpackage

module register_status_file
    import register_status_file_pkg::*;
#(
    parameter int NUM_READ_PORTS = 2,
    parameter int WIDTH          = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           fls_i,
    input  logic                                           commit_i,
    input  logic [4:0]                                     commit_idx_i,
    input  logic [WIDTH-1:0]                               commit_val_i,
    input  logic [ROB_IDX_LEN-1:0]                         commit_rob_idx_i,
    input  logic                                           speculate_i,
    input  logic [4:0]                                     speculate_idx_i,
    input  logic [ROB_IDX_LEN-1:0]                         speculate_val_i,
    input  rob_element_t [ROB_ENTRIES-1:0]                 rob_bus_i,
    input  common_data_bus_t                               common_data_bus_i,
    input  logic [NUM_READ_PORTS-1:0][4:0]                 rs_idx_i,
    output logic [NUM_READ_PORTS-1:0]                      rs_rdy_o,
    output logic [NUM_READ_PORTS-1:0][WIDTH-1:0]           rs_val_o,
    output logic [NUM_READ_PORTS-1:0][ROB_IDX_LEN-1:0]     rs_tag_o,
    output logic [5:0]                                     busy_count_o
);

    logic [31:0][WIDTH-1:0]       r_value;
    logic [31:0]                  r_busy;
    logic [31:0][ROB_IDX_LEN-1:0] r_tag;
    logic [5:0]                   r_busy_count;

    logic [31:0] w_busy_nxt;
    logic [5:0]  w_busy_count_nxt;
    logic        w_commit_wr;
    logic        w_spec_wr;

    assign w_commit_wr = commit_i && (commit_idx_i != 5'd0);
    assign w_spec_wr   = speculate_i && (speculate_idx_i != 5'd0) && !fls_i;

    // Commit clears busy only when it retires the producer the register
    // still points at; speculate is applied afterwards so it wins a tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (fls_i) begin
            w_busy_nxt = '0;
        end else begin
            if (w_commit_wr && r_busy[commit_idx_i] &&
                (r_tag[commit_idx_i] == commit_rob_idx_i)) begin
                w_busy_nxt[commit_idx_i] = 1'b0;
            end
            if (w_spec_wr) begin
                w_busy_nxt[speculate_idx_i] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_count_nxt = 6'd0;
        for (int i = 1; i < 32; i++) begin
            w_busy_count_nxt = w_busy_count_nxt + {5'd0, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value      <= '0;
            r_busy       <= '0;
            r_tag        <= '0;
            r_busy_count <= 6'd0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_count_nxt;
            if (w_commit_wr) begin
                r_value[commit_idx_i] <= commit_val_i;
            end
            if (w_spec_wr) begin
                r_tag[speculate_idx_i] <= speculate_val_i;
            end
        end
    end

    assign busy_count_o = r_busy_count;

    // Lookups see only registered state, so an instruction reading its own
    // destination gets the mapping from before its own rename.
    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [4:0]             w_idx;
        logic [ROB_IDX_LEN-1:0] w_tag;
        logic                   w_cdb_hit;
        logic [WIDTH-1:0]       w_cdb_data;
        logic                   w_rdy;
        logic [WIDTH-1:0]       w_val;
        logic [ROB_IDX_LEN-1:0] w_tag_out;

        assign w_idx = rs_idx_i[p];
        assign w_tag = r_tag[w_idx];

        // Scan from the top lane down so the lowest matching lane overrides.
        always_comb begin
            w_cdb_hit  = 1'b0;
            w_cdb_data = '0;
            for (int l = CDB_LANES - 1; l >= 0; l--) begin
                if (common_data_bus_i[l].valid &&
                    (common_data_bus_i[l].rob_dest == w_tag)) begin
                    w_cdb_hit  = 1'b1;
                    w_cdb_data = WIDTH'(common_data_bus_i[l].data);
                end
            end
        end

        always_comb begin
            w_rdy     = 1'b1;
            w_val     = '0;
            w_tag_out = '0;
            if (w_idx == 5'd0) begin
                w_rdy = 1'b1;
            end else if (!r_busy[w_idx]) begin
                w_val = r_value[w_idx];
            end else begin
                w_tag_out = w_tag;
                if (rob_bus_i[w_tag].rdy) begin
                    w_val = WIDTH'(rob_bus_i[w_tag].val);
                end else if (w_cdb_hit) begin
                    w_val = w_cdb_data;
                end else begin
                    w_rdy = 1'b0;
                end
            end
        end

        assign rs_rdy_o[p] = w_rdy;
        assign rs_val_o[p] = w_val;
        assign rs_tag_o[p] = w_tag_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_register_status_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_status_file                                                 |
// | Self-checking bench: directed scenarios plus randomized traffic against |
// | an array-based reference model of the rename status rules.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_register_status_file;
    import register_status_file_pkg::*;

    localparam int NP = 2;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              fls_i;
    logic                              commit_i;
    logic [4:0]                        commit_idx_i;
    logic [31:0]                       commit_val_i;
    logic [ROB_IDX_LEN-1:0]            commit_rob_idx_i;
    logic                              speculate_i;
    logic [4:0]                        speculate_idx_i;
    logic [ROB_IDX_LEN-1:0]            speculate_val_i;
    rob_element_t [ROB_ENTRIES-1:0]    rob_bus_i;
    common_data_bus_t                  common_data_bus_i;
    logic [NP-1:0][4:0]                rs_idx_i;
    logic [NP-1:0]                     rs_rdy_o;
    logic [NP-1:0][31:0]               rs_val_o;
    logic [NP-1:0][ROB_IDX_LEN-1:0]    rs_tag_o;
    logic [5:0]                        busy_count_o;

    register_status_file #(.NUM_READ_PORTS(NP), .WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .fls_i             (fls_i),
        .commit_i          (commit_i),
        .commit_idx_i      (commit_idx_i),
        .commit_val_i      (commit_val_i),
        .commit_rob_idx_i  (commit_rob_idx_i),
        .speculate_i       (speculate_i),
        .speculate_idx_i   (speculate_idx_i),
        .speculate_val_i   (speculate_val_i),
        .rob_bus_i         (rob_bus_i),
        .common_data_bus_i (common_data_bus_i),
        .rs_idx_i          (rs_idx_i),
        .rs_rdy_o          (rs_rdy_o),
        .rs_val_o          (rs_val_o),
        .rs_tag_o          (rs_tag_o),
        .busy_count_o      (busy_count_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]            m_val  [32];
    bit                     m_busy [32];
    logic [ROB_IDX_LEN-1:0] m_tag  [32];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_busy_count();
        int c = 0;
        for (int i = 1; i < 32; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
        end
    endtask

    // Apply one clock edge's worth of updates using the inputs present at it.
    task automatic model_edge();
        bit clr;
        if (rst) begin
            model_reset();
            return;
        end
        clr = commit_i && commit_idx_i != 0 && m_busy[commit_idx_i] &&
              m_tag[commit_idx_i] == commit_rob_idx_i;
        if (commit_i && commit_idx_i != 0) m_val[commit_idx_i] = commit_val_i;
        if (fls_i) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (clr) m_busy[commit_idx_i] = 0;
            if (speculate_i && speculate_idx_i != 0) begin
                m_busy[speculate_idx_i] = 1;
                m_tag[speculate_idx_i]  = speculate_val_i;
            end
        end
    endtask

    task automatic check_lookups();
        logic [4:0]             idx;
        logic [ROB_IDX_LEN-1:0] t;
        bit                     hit;
        logic [31:0]            d;
        for (int p = 0; p < NP; p++) begin
            idx = rs_idx_i[p];
            if (idx == 0 || !m_busy[idx]) begin
                check_value($sformatf("rdy[%0d] x%0d", p, idx), rs_rdy_o[p], 1);
                check_value($sformatf("val[%0d] x%0d", p, idx), rs_val_o[p], (idx == 0) ? 32'd0 : m_val[idx]);
                check_value($sformatf("tag[%0d] x%0d", p, idx), rs_tag_o[p], 0);
            end else begin
                t = m_tag[idx];
                hit = 0; d = '0;
                for (int l = 0; l < CDB_LANES; l++) begin
                    if (!hit && common_data_bus_i[l].valid && common_data_bus_i[l].rob_dest == t) begin
                        hit = 1; d = common_data_bus_i[l].data;
                    end
                end
                if (rob_bus_i[t].rdy) begin
                    check_value($sformatf("rdy[%0d] rob x%0d", p, idx), rs_rdy_o[p], 1);
                    check_value($sformatf("val[%0d] rob x%0d", p, idx), rs_val_o[p], rob_bus_i[t].val);
                    check_value($sformatf("tag[%0d] rob x%0d", p, idx), rs_tag_o[p], t);
                end else if (hit) begin
                    check_value($sformatf("rdy[%0d] cdb x%0d", p, idx), rs_rdy_o[p], 1);
                    check_value($sformatf("val[%0d] cdb x%0d", p, idx), rs_val_o[p], d);
                end else begin
                    check_value($sformatf("rdy[%0d] pend x%0d", p, idx), rs_rdy_o[p], 0);
                    check_value($sformatf("val[%0d] pend x%0d", p, idx), rs_val_o[p], 0);
                    check_value($sformatf("tag[%0d] pend x%0d", p, idx), rs_tag_o[p], t);
                end
            end
        end
    endtask

    task automatic idle();
        rst = 0; fls_i = 0;
        commit_i = 0; commit_idx_i = '0; commit_val_i = '0; commit_rob_idx_i = '0;
        speculate_i = 0; speculate_idx_i = '0; speculate_val_i = '0;
        rob_bus_i = '0; common_data_bus_i = '0;
    endtask

    // Called at a negedge with inputs set: check lookups, clock, check count.
    task automatic cyc();
        #1;
        check_lookups();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_value("busy_count", busy_count_o, model_busy_count());
    endtask

    initial begin
        idle();
        rs_idx_i = '0;
        model_reset();
        @(negedge clk);

        // 1: reset
        rst = 1; cyc(); cyc(); idle();
        rs_idx_i[0] = 5'd5; rs_idx_i[1] = 5'd31;
        #1;
        check_value("t1 rdy x5", rs_rdy_o[0], 1);
        check_value("t1 val x5", rs_val_o[0], 0);
        check_value("t1 rdy x31", rs_rdy_o[1], 1);
        check_value("t1 val x31", rs_val_o[1], 0);
        check_value("t1 busy_count", busy_count_o, 0);
        cyc();

        // 2: speculate x3 -> tag 4, CDB forward
        speculate_i = 1; speculate_idx_i = 5'd3; speculate_val_i = 4'd4;
        rs_idx_i[0] = 5'd3;
        #1;
        check_value("t2 own-dest old mapping", rs_rdy_o[0], 1);
        cyc(); idle();
        rs_idx_i[0] = 5'd3; rs_idx_i[1] = 5'd3;
        #1;
        check_value("t2 rdy pending", rs_rdy_o[0], 0);
        check_value("t2 tag pending", rs_tag_o[0], 4);
        common_data_bus_i[1].valid = 1; common_data_bus_i[1].rob_dest = 4'd4; common_data_bus_i[1].data = 32'h77;
        common_data_bus_i[0].valid = 1; common_data_bus_i[0].rob_dest = 4'd4; common_data_bus_i[0].data = 32'hAB;
        #1;
        check_value("t2 rdy cdb", rs_rdy_o[1], 1);
        check_value("t2 val cdb lowest lane", rs_val_o[1], 32'hAB);
        cyc(); idle();

        // 3: rename twice, commit older producer
        rst = 1; cyc(); idle();
        speculate_i = 1; speculate_idx_i = 5'd3; speculate_val_i = 4'd4; cyc();
        speculate_val_i = 4'd6; cyc(); idle();
        commit_i = 1; commit_idx_i = 5'd3; commit_rob_idx_i = 4'd4; commit_val_i = 32'd7; cyc(); idle();
        rs_idx_i[0] = 5'd3;
        #1;
        check_value("t3 still busy", rs_rdy_o[0], 0);
        check_value("t3 tag 6", rs_tag_o[0], 6);
        check_value("t3 busy_count", busy_count_o, 1);
        cyc();

        // 4: commit and speculate same register, then read through ROB
        commit_i = 1; commit_idx_i = 5'd7; commit_rob_idx_i = 4'd2; commit_val_i = 32'h55;
        speculate_i = 1; speculate_idx_i = 5'd7; speculate_val_i = 4'd9;
        cyc(); idle();
        rs_idx_i[0] = 5'd7; rs_idx_i[1] = 5'd3;
        #1;
        check_value("t4 busy", rs_rdy_o[0], 0);
        check_value("t4 tag 9", rs_tag_o[0], 9);
        rob_bus_i[9].rdy = 1; rob_bus_i[9].val = 32'h99;
        #1;
        check_value("t4 rob rdy", rs_rdy_o[0], 1);
        check_value("t4 rob val", rs_val_o[0], 32'h99);
        cyc(); idle();
        fls_i = 1; cyc(); idle();
        #1;
        check_value("t4 committed value", rs_val_o[0], 32'h55);
        check_value("t3 committed value", rs_val_o[1], 32'd7);
        cyc();

        // 5: three busy, flush with commit
        speculate_i = 1;
        speculate_idx_i = 5'd1; speculate_val_i = 4'd1; cyc();
        speculate_idx_i = 5'd2; speculate_val_i = 4'd2; cyc();
        speculate_idx_i = 5'd4; speculate_val_i = 4'd3; cyc(); idle();
        check_value("t5 three busy", busy_count_o, 3);
        fls_i = 1; commit_i = 1; commit_idx_i = 5'd1; commit_rob_idx_i = 4'd0; commit_val_i = 32'h10;
        speculate_i = 1; speculate_idx_i = 5'd2; speculate_val_i = 4'd5;
        cyc(); idle();
        rs_idx_i[0] = 5'd1; rs_idx_i[1] = 5'd2;
        #1;
        check_value("t5 x1 rdy", rs_rdy_o[0], 1);
        check_value("t5 x1 val", rs_val_o[0], 32'h10);
        check_value("t5 x2 rdy", rs_rdy_o[1], 1);
        check_value("t5 busy_count", busy_count_o, 0);
        cyc();

        // 6: writes to x0
        speculate_i = 1; speculate_idx_i = 5'd5; speculate_val_i = 4'd8; cyc(); idle();
        commit_i = 1; commit_idx_i = 5'd0; commit_val_i = 32'hFFFF;
        speculate_i = 1; speculate_idx_i = 5'd0; speculate_val_i = 4'd5;
        cyc(); idle();
        rs_idx_i[0] = 5'd0;
        #1;
        check_value("t6 x0 rdy", rs_rdy_o[0], 1);
        check_value("t6 x0 val", rs_val_o[0], 0);
        check_value("t6 busy_count", busy_count_o, 1);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst   = ($urandom_range(0, 149) == 0);
            fls_i = ($urandom_range(0, 24) == 0);
            commit_i = $urandom_range(0, 1);
            commit_idx_i = ($urandom_range(0, 9) == 0) ? 5'(31) : 5'($urandom_range(0, 7));
            commit_val_i = $urandom;
            commit_rob_idx_i = $urandom_range(0, 1) ? m_tag[commit_idx_i] : ROB_IDX_LEN'($urandom);
            speculate_i = $urandom_range(0, 1);
            speculate_idx_i = ($urandom_range(0, 9) == 0) ? 5'(31) : 5'($urandom_range(0, 7));
            speculate_val_i = ROB_IDX_LEN'($urandom);
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                rob_bus_i[e].rdy = ($urandom_range(0, 3) == 0);
                rob_bus_i[e].val = $urandom;
            end
            for (int l = 0; l < CDB_LANES; l++) begin
                common_data_bus_i[l].valid    = $urandom_range(0, 1);
                common_data_bus_i[l].rob_dest = ROB_IDX_LEN'($urandom);
                common_data_bus_i[l].data     = $urandom;
            end
            rs_idx_i[0] = 5'($urandom_range(0, 7));
            rs_idx_i[1] = ($urandom_range(0, 3) == 0) ? 5'(31) : 5'($urandom_range(0, 7));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
